// File: rtl/video_pattern_gen.sv
// Two-stage pipelined test-pattern generator: gray, primaries, scrolling rainbow, composite, checker.
// Optional macro VIDEO_PATTERN_BORDER_EN draws a white one-pixel frame border over every mode.
module video_pattern_gen #(
    parameter int HSIZE      = 11,
    parameter int VSIZE      = 11,
    parameter int HDISPLAY   = 640,
    parameter int VDISPLAY   = 480,
    parameter int CW         = 4,
    parameter int GRAY_SHIFT = 5,
    parameter int PRIM_SHIFT = 6,
    parameter int CHK_SHIFT  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HSIZE-1:0]  hc,
    input  logic [VSIZE-1:0]  vc,
    input  logic              in_valid,
    input  logic              frame_start,
    input  logic [2:0]        mode,
    input  logic [3:0]        scroll_div,
    input  logic [HSIZE-1:0]  scroll_step,
    output logic              out_valid,
    output logic [3*CW-1:0]   rgb
);

    typedef enum logic [2:0] {
        MODE_GRAY    = 3'd0,
        MODE_PRIM    = 3'd1,
        MODE_RAINBOW = 3'd2,
        MODE_COMP    = 3'd3,
        MODE_CHECK   = 3'd4
    } mode_e;

    localparam logic [VSIZE-1:0] V_BAND1 = VSIZE'(VDISPLAY / 3);
    localparam logic [VSIZE-1:0] V_BAND2 = VSIZE'(2 * (VDISPLAY / 3));

    logic [2:0]       r_mode_act;
    logic [3:0]       r_frame_cnt;
    logic [HSIZE-1:0] r_offset;

    logic             r_s1_valid;
    logic [HSIZE-1:0] r_s1_hc;
    logic [HSIZE-1:0] r_s1_hx;
    logic [VSIZE-1:0] r_s1_vc;
    logic [2:0]       r_s1_mode;

    logic [HSIZE-1:0] w_gray_full;
    logic [HSIZE-1:0] w_prim_full;
    logic [CW-1:0]    w_full;
    logic [CW-1:0]    w_zero;
    logic [CW-1:0]    w_gray;
    logic [2:0]       w_prim;
    logic [CW-1:0]    w_up;
    logic [CW-1:0]    w_dn;
    logic [3*CW-1:0]  w_gray_rgb;
    logic [3*CW-1:0]  w_prim_rgb;
    logic [3*CW-1:0]  w_rain_rgb;
    logic [3*CW-1:0]  w_chk_rgb;
    logic [3*CW-1:0]  w_comp_rgb;
    logic [3*CW-1:0]  w_colour;
    logic             w_border;
    logic             w_unused;

    assign w_full      = '1;
    assign w_zero      = '0;
    assign w_gray_full = r_s1_hc >> GRAY_SHIFT;
    assign w_prim_full = r_s1_hc >> PRIM_SHIFT;
    assign w_gray      = w_gray_full[CW-1:0];
    assign w_prim      = w_prim_full[2:0];
    assign w_up        = r_s1_hx[6 -: CW];
    assign w_dn        = ~w_up;
    assign w_unused    = ^{r_s1_hx, r_s1_hc, r_s1_vc, w_gray_full, w_prim_full};

    assign w_gray_rgb  = {w_gray, w_gray, w_gray};
    assign w_prim_rgb  = {{CW{w_prim[2]}}, {CW{w_prim[1]}}, {CW{w_prim[0]}}};
    assign w_chk_rgb   = (r_s1_hc[CHK_SHIFT] ^ r_s1_vc[CHK_SHIFT]) ? '1 : '0;

    always_comb begin
        w_rain_rgb = '1;
        case (r_s1_hx[9:7])
            3'd0:    w_rain_rgb = {w_full, w_up,   w_zero};
            3'd1:    w_rain_rgb = {w_dn,   w_full, w_zero};
            3'd2:    w_rain_rgb = {w_zero, w_full, w_up};
            3'd3:    w_rain_rgb = {w_zero, w_dn,   w_full};
            3'd4:    w_rain_rgb = {w_up,   w_zero, w_full};
            3'd5:    w_rain_rgb = {w_full, w_zero, w_dn};
            default: w_rain_rgb = '1;
        endcase
    end

    always_comb begin
        w_comp_rgb = w_rain_rgb;
        if (r_s1_vc < V_BAND1)
            w_comp_rgb = w_gray_rgb;
        else if (r_s1_vc < V_BAND2)
            w_comp_rgb = w_prim_rgb;
    end

`ifdef VIDEO_PATTERN_BORDER_EN
    assign w_border = (r_s1_hc == '0) || (r_s1_hc == HSIZE'(HDISPLAY - 1)) ||
                      (r_s1_vc == '0) || (r_s1_vc == VSIZE'(VDISPLAY - 1));
`else
    assign w_border = 1'b0;
`endif

    // Unused mode codes 5..7 fall through to the composite pattern.
    always_comb begin
        w_colour = w_comp_rgb;
        case (r_s1_mode)
            MODE_GRAY:    w_colour = w_gray_rgb;
            MODE_PRIM:    w_colour = w_prim_rgb;
            MODE_RAINBOW: w_colour = w_rain_rgb;
            MODE_CHECK:   w_colour = w_chk_rgb;
            default:      w_colour = w_comp_rgb;
        endcase
        if (w_border)
            w_colour = '1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode_act  <= '0;
            r_frame_cnt <= '0;
            r_offset    <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_hc     <= '0;
            r_s1_hx     <= '0;
            r_s1_vc     <= '0;
            r_s1_mode   <= '0;
            out_valid   <= 1'b0;
            rgb         <= '0;
        end else begin
            if (frame_start) begin
                r_mode_act <= mode;
                if (scroll_div == 4'd0) begin
                    r_frame_cnt <= '0;
                end else if (r_frame_cnt == scroll_div - 4'd1) begin
                    r_frame_cnt <= '0;
                    r_offset    <= r_offset + scroll_step;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 4'd1;
                end
            end
            // Stage 1 samples the pre-update mode/offset when frame_start coincides with a pixel.
            r_s1_valid <= in_valid;
            r_s1_hc    <= hc;
            r_s1_hx    <= hc + r_offset;
            r_s1_vc    <= vc;
            r_s1_mode  <= r_mode_act;
            out_valid  <= r_s1_valid;
            rgb        <= r_s1_valid ? w_colour : '0;
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: directed pixels push expected colour and issue cycle.
// Build with +define+VIDEO_PATTERN_BORDER_EN to check the border variant.
module tb_video_pattern_gen;

`ifdef VIDEO_PATTERN_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        in_valid;
    logic        frame_start;
    logic [2:0]  mode;
    logic [3:0]  scroll_div;
    logic [10:0] scroll_step;
    logic        out_valid;
    logic [11:0] rgb;

    video_pattern_gen #(
        .HSIZE(11), .VSIZE(11), .HDISPLAY(640), .VDISPLAY(480),
        .CW(4), .GRAY_SHIFT(5), .PRIM_SHIFT(6), .CHK_SHIFT(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hc(hc), .vc(vc), .in_valid(in_valid),
        .frame_start(frame_start), .mode(mode), .scroll_div(scroll_div),
        .scroll_step(scroll_step), .out_valid(out_valid), .rgb(rgb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] rgb;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every valid output must match the oldest expectation, two cycles after issue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid: rgb=%03h cyc=%0d, required no output", rgb, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (rgb !== e.rgb || cyc != e.cyc + 2) begin
                        failures++;
                        $display("FAIL %s: rgb=%03h cyc=%0d, required rgb=%03h cyc=%0d",
                                 e.name, rgb, cyc, e.rgb, e.cyc + 2);
                    end
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0 || rgb !== 12'h000) begin
                    failures++;
                    $display("FAIL idle_out: out_valid=%b rgb=%03h, required 0/000", out_valid, rgb);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [10:0] h, input logic [10:0] v,
                       input logic [11:0] e, input string nm);
        exp_t x;
        hc = h; vc = v; in_valid = 1'b1;
        x.rgb = e; x.cyc = cyc; x.name = nm;
        q.push_back(x);
        step();
        in_valid = 1'b0;
    endtask

    task automatic fs(input logic [2:0] m);
        frame_start = 1'b1; mode = m;
        step();
        frame_start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        step();
        step();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d, required 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0; hc = 11'd37; vc = 11'd10; in_valid = 1'b1;
        frame_start = 1'b0; mode = 3'd0; scroll_div = 4'd0; scroll_step = 11'd0;
        step();
        mon_en = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || rgb !== 12'h000) begin
            failures++;
            $display("FAIL reset_out: out_valid=%b rgb=%03h, required 0/000", out_valid, rgb);
        end
        #1;
        step();
        rst_n = 1'b1; in_valid = 1'b0;

        // mode_act stays gray until a frame_start arrives
        mode = 3'd2;
        pix(11'd37, 11'd10, 12'h111, "post_reset_gray");
        step(); step();

        fs(3'd0);
        pix(11'd37, 11'd10, 12'h111, "gray_37");
        pix(11'd100, 11'd10, 12'h333, "gray_100");
        step(); step();

        fs(3'd2);
        pix(11'd200, 11'd10, 12'h6F0, "rain_200");
        pix(11'd20, 11'd10, 12'hF20, "rain_20");
        pix(11'd600, 11'd10, 12'hB0F, "rain_600");
        pix(11'd400, 11'd10, 12'h0DF, "rain_400");

        scroll_div = 4'd2; scroll_step = 11'd16;
        fs(3'd2);
        pix(11'd184, 11'd10, 12'h8F0, "scroll_off0");
        fs(3'd2);
        pix(11'd184, 11'd10, 12'h6F0, "scroll_off16");
        fs(3'd2);
        pix(11'd184, 11'd10, 12'h6F0, "scroll_hold16");
        // frame_start together with a pixel: the pixel sees offset 16, later pixels 32
        frame_start = 1'b1; mode = 3'd2;
        pix(11'd184, 11'd10, 12'h6F0, "fs_same_cycle");
        frame_start = 1'b0;
        pix(11'd184, 11'd10, 12'h4F0, "scroll_off32");
        scroll_div = 4'd0;

        fs(3'd3);
        pix(11'd320, 11'd200, 12'hF0F, "comp_prim");
        pix(11'd37, 11'd10, 12'h111, "comp_gray");
        pix(11'd184, 11'd400, 12'h4F0, "comp_rain_scroll");
        mode = 3'd4;
        pix(11'd320, 11'd200, 12'hF0F, "mode_no_fs");
        fs(3'd4);
        pix(11'd32, 11'd0, 12'hFFF, "chk_32_0");
        pix(11'd32, 11'd32, 12'h000, "chk_32_32");
        pix(11'd64, 11'd32, 12'hFFF, "chk_64_32");
        fs(3'd6);
        pix(11'd320, 11'd200, 12'hF0F, "mode6_comp");

        fs(3'd0);
        pix(11'd0, 11'd100, BORDER ? 12'hFFF : 12'h000, "border_left");
        pix(11'd639, 11'd100, BORDER ? 12'hFFF : 12'h333, "border_right");
        pix(11'd100, 11'd479, BORDER ? 12'hFFF : 12'h333, "border_bottom");
        drain();

        // Mid-frame reset clears mode_act and offset
        fs(3'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        pix(11'd200, 11'd10, 12'h666, "reset_mode_clear");
        fs(3'd2);
        pix(11'd200, 11'd10, 12'h6F0, "reset_offset_clear");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Parametrised, pipelined successor to the fixed 640x480 bar generator.
- Produces gray ramp, 8-primary bars, rainbow spectrum, three-band composite and checkerboard patterns at configurable colour depth.
- Adds frame-synchronous mode switching and horizontal scrolling of the rainbow.
- Sits between the video timing core (hc/vc/frame_start) and the video core mux.

Parameters:
- HSIZE, 11, width of hc.
- VSIZE, 11, width of vc.
- HDISPLAY, 640, active pixels per line.
- VDISPLAY, 480, active lines per frame.
- CW, 4, bits per colour channel (legal range 1..7).
- GRAY_SHIFT, 5, hc right-shift giving the gray level.
- PRIM_SHIFT, 6, hc right-shift giving the 3-bit primary index.
- CHK_SHIFT, 5, checker square size is 2^CHK_SHIFT pixels.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous reset, active low.
- hc  in  HSIZE  horizontal pixel count.
- vc  in  VSIZE  vertical line count.
- in_valid  in  1  hc/vc inside active display.
- frame_start  in  1  one-cycle pulse at the start of each frame.
- mode  in  3  requested pattern: 0 gray, 1 primary, 2 rainbow, 3 composite, 4 checker, 5-7 treated as 3.
- scroll_div  in  4  frames per scroll step; 0 disables scrolling.
- scroll_step  in  HSIZE  pixels added to the offset per scroll step.
- out_valid  out  1  rgb qualifier.
- rgb  out  3*CW  {r,g,b}, each CW bits.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, rgb=0, mode_act=0, frame_cnt=0, offset=0, all pipeline registers 0. Reset may be applied mid-frame; the first valid output after release follows the normal 2-cycle latency.
- Frame-synchronous state, updated only on cycles where frame_start=1:
  - mode_act <= mode.
  - If scroll_div=0: frame_cnt <= 0, offset holds.
  - Else if frame_cnt == scroll_div-1: frame_cnt <= 0, offset <= offset + scroll_step (mod 2^HSIZE).
  - Else: frame_cnt <= frame_cnt+1.
  - A mode change without frame_start has no effect on output.
- Simultaneous frame_start and in_valid: that pixel uses the pre-update mode_act/offset.
- Stage 1 (registered): s1_valid, s1_hc = hc, s1_hx = hc + offset (mod 2^HSIZE), s1_vc, s1_mode = mode_act.
- Stage 2 (registered): out_valid <= s1_valid; rgb <= colour(s1) if s1_valid, else 0. Latency is exactly 2 cycles, fully pipelined, 1 pixel/cycle, no backpressure.
- Colour functions (F = all-ones CW bits):
  - gray: each channel = (hc>>GRAY_SHIFT)[CW-1:0].
  - primary: p = (hc>>PRIM_SHIFT)[2:0]; r={CW{p[2]}}, g={CW{p[1]}}, b={CW{p[0]}}.
  - rainbow: seg = hx[9:7]; up = hx[6 -: CW]; dn = ~up.
    - seg 0: (F, up, 0); 1: (dn, F, 0); 2: (0, F, up); 3: (0, dn, F); 4: (up, 0, F); 5: (F, 0, dn); 6-7: white.
    - Scrolling applies to rainbow only, including the rainbow band of composite.
  - composite: vc < VDISPLAY/3 gray; vc < 2*(VDISPLAY/3) primary; else rainbow. Integer division is fixed at elaboration.
  - checker: white if hc[CHK_SHIFT]^vc[CHK_SHIFT], else 0.
- No internal division or multiplication at runtime; all widths truncate modulo.

Optional Feature:
- Macro VIDEO_PATTERN_BORDER_EN.
- Defined: stage 2 forces rgb to white when s1_valid and (hc==0 or hc==HDISPLAY-1 or vc==0 or vc==VDISPLAY-1). This overrides every mode; latency is unchanged.
- Undefined: no border logic; pattern output only.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, rgb=0x000; after release, mode_act=0 until the first frame_start.
- Gray mode (CW=4): frame_start with mode=0, then hc=37, vc=10, in_valid=1 -> two cycles later out_valid=1, rgb=0x111. With in_valid=0 -> rgb=0x000, out_valid=0.
- Rainbow, no scroll: mode=2, scroll_div=0, hc=200 -> rgb=0x6F0 (seg 1, dn=6).
- Scrolling: mode=2, scroll_div=2, scroll_step=16, two frame_start pulses -> offset=16; then hc=184 -> rgb=0x6F0. A third pulse leaves the offset at 16.
- Composite and mode sync: mode_act=3, hc=320, vc=200 -> rgb=0xF0F. Drive mode=4 mid-frame -> output unchanged until the next frame_start. Then hc=32, vc=0 -> 0xFFF; hc=32, vc=32 -> 0x000.
- Border (macro defined): any mode, hc=0, vc=100, in_valid=1 -> rgb=0xFFF. Macro undefined: same stimulus gives the pattern colour.
